// File: rtl/fwd_hazard_unit_if.sv
// Signal bundle between the ID/EX pipeline control (master) and the forwarding/hazard unit (slave).
// dbg_lu_wait/dbg_cnt expose the load-use sequencer state.
interface fwd_hazard_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*REG_AW-1:0] rs_ex;
    logic [NUM_SRC*REG_AW-1:0] rs_id;
    logic [NUM_SRC-1:0]        rs_id_vld;
    logic [REG_AW-1:0]         rd_ex;
    logic                      regwrite_ex;
    logic                      memread_ex;
    logic [REG_AW-1:0]         rd_mem;
    logic                      regwrite_mem;
    logic                      memread_mem;
    logic [REG_AW-1:0]         rd_wb;
    logic                      regwrite_wb;
    logic                      long_issue;
    logic [REG_AW-1:0]         long_rd;
    logic                      long_done;
    logic [REG_AW-1:0]         long_done_rd;
    logic                      flush;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall_id;
    logic                      bubble_ex;
    logic [1:0]                stall_cause;
    logic                      dbg_lu_wait;
    logic [2:0]                dbg_cnt;

    modport master (
        output rs_ex, rs_id, rs_id_vld, rd_ex, regwrite_ex, memread_ex,
               rd_mem, regwrite_mem, memread_mem, rd_wb, regwrite_wb,
               long_issue, long_rd, long_done, long_done_rd, flush,
        input  fwd_sel, stall_id, bubble_ex, stall_cause, dbg_lu_wait, dbg_cnt
    );

    modport slave (
        input  rs_ex, rs_id, rs_id_vld, rd_ex, regwrite_ex, memread_ex,
               rd_mem, regwrite_mem, memread_mem, rd_wb, regwrite_wb,
               long_issue, long_rd, long_done, long_done_rd, flush,
        output fwd_sel, stall_id, bubble_ex, stall_cause, dbg_lu_wait, dbg_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding (MEM over WB), load-use stall sequencing with extra load latency,
// and a per-register busy scoreboard for long-latency results.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_unit_if.slave hz
);
    localparam int         NREG = 2 ** REG_AW;
    localparam logic [2:0] LAT3 = 3'(LOAD_LAT);

    typedef enum logic {IDLE, LU_WAIT} lu_state_e;

    lu_state_e       state_q;
    logic [2:0]      cnt_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            luh;
    logic            sbh;
    logic [1:0]      cause;
    logic            stall_any;
    logic            stall_w;
    logic            issue_ok;

    // A load sitting in MEM has no data yet, so it is skipped and the WB match may still apply.
    always_comb begin
        hz.fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hz.regwrite_mem && (hz.rd_mem != '0) && !hz.memread_mem &&
                (hz.rd_mem == hz.rs_ex[i*REG_AW +: REG_AW]))
                hz.fwd_sel[2*i +: 2] = 2'b10;
            else if (hz.regwrite_wb && (hz.rd_wb != '0) &&
                     (hz.rd_wb == hz.rs_ex[i*REG_AW +: REG_AW]))
                hz.fwd_sel[2*i +: 2] = 2'b01;
        end
    end

    always_comb begin
        luh = 1'b0;
        sbh = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hz.rs_id_vld[i]) begin
                if (hz.rs_id[i*REG_AW +: REG_AW] == hz.rd_ex) luh = 1'b1;
                if (busy_q[hz.rs_id[i*REG_AW +: REG_AW]])     sbh = 1'b1;
            end
        end
        luh = luh && hz.memread_ex && hz.regwrite_ex && (hz.rd_ex != '0);
    end

    assign cause     = {sbh, luh || (state_q == LU_WAIT)};
    assign stall_any = |cause;
    assign stall_w   = stall_any && !hz.flush;

    assign hz.stall_cause = cause;
    assign hz.bubble_ex   = stall_any;
    assign hz.stall_id    = stall_w;
    assign hz.dbg_lu_wait = (state_q == LU_WAIT);
    assign hz.dbg_cnt     = cnt_q;

    // Issue is applied after completion so a same-cycle reissue of the register stays busy.
    always_comb begin
        busy_d   = busy_q;
        issue_ok = hz.long_issue && (hz.long_rd != '0) && !stall_w;
        if (hz.long_done) busy_d[hz.long_done_rd] = 1'b0;
        if (issue_ok)     busy_d[hz.long_rd]      = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (hz.flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (luh && (LOAD_LAT > 0)) begin
                            state_q <= LU_WAIT;
                            cnt_q   <= LAT3;
                        end
                    end
                    LU_WAIT: begin
                        if (cnt_q == 3'd1) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end
endmodule
